// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Shares one single-port synchronous memory between the CPU
//             instruction-fetch port and data port. One requester is served at
//             a time. Each access runs through four steps:
//               - the arbiter issues a one-cycle mem_ce access;
//               - it waits MEM_LAT cycles;
//               - it captures mem_rdata;
//               - it pulses the owner's ack for one cycle.
//             The data port has priority, but a pending fetch wins after
//             STARVE_MAX consecutive data grants.
//  Ports    :
//    clk, rst                  clock, asynchronous active-high reset
//    if_req/if_addr            fetch request and byte address
//    if_rdata/if_ack           fetch read data, one-cycle completion pulse
//    d_req/d_we/d_sel          data request, write enable, byte enables
//    d_addr/d_wdata            data byte address and write data
//    d_rdata/d_ack             data read data, one-cycle completion pulse
//    stallreq                  pipeline stall while any request is outstanding
//    mem_ce/mem_we/mem_sel     memory chip enable, write enable, byte enables
//    mem_addr/mem_wdata        memory address and write data
//    mem_rdata                 memory read data
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        stallreq,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        grant_d, grant_d_nxt;     // 1 = data port owns the transaction
  logic        grant_we, grant_we_nxt;   // owner's access is a write
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [3:0]  starve_cnt, starve_cnt_nxt;
  logic        mem_ce_nxt, mem_we_nxt;
  logic [3:0]  mem_sel_nxt;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt;
  logic        if_ack_nxt, d_ack_nxt;
  logic [31:0] if_rdata_nxt, d_rdata_nxt;

  // Data wins unless a fetch is waiting and has already been passed over
  // STARVE_MAX times in a row.
  logic grant_data_w;
  assign grant_data_w = d_req & (~if_req | (starve_cnt < STARVE_LIM));

  always_comb begin
    state_nxt      = state;
    grant_d_nxt    = grant_d;
    grant_we_nxt   = grant_we;
    wait_cnt_nxt   = wait_cnt;
    starve_cnt_nxt = starve_cnt;
    // Memory strobes are only non-zero during the single ACCESS cycle.
    mem_ce_nxt     = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_sel_nxt    = 4'b0000;
    mem_addr_nxt   = 32'h0;
    mem_wdata_nxt  = 32'h0;
    if_ack_nxt     = 1'b0;
    d_ack_nxt      = 1'b0;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;

    case (state)
      IDLE: begin
        if (grant_data_w) begin
          state_nxt     = ACCESS;
          grant_d_nxt   = 1'b1;
          grant_we_nxt  = d_we;
          mem_ce_nxt    = 1'b1;
          mem_we_nxt    = d_we;
          mem_sel_nxt   = d_sel;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          if (if_req)
            starve_cnt_nxt = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
        end else if (if_req) begin
          state_nxt      = ACCESS;
          grant_d_nxt    = 1'b0;
          grant_we_nxt   = 1'b0;
          mem_ce_nxt     = 1'b1;
          mem_sel_nxt    = 4'b1111;
          mem_addr_nxt   = if_addr;
          starve_cnt_nxt = 4'd0;
        end
      end
      ACCESS: begin
        wait_cnt_nxt = LAT_LOAD;
        state_nxt    = WAIT;
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        // wait_cnt==1 marks the cycle mem_rdata is valid.
        if (wait_cnt <= 4'd1) begin
          wait_cnt_nxt = 4'd0;
          state_nxt    = RESP;
          if (grant_d) begin
            d_rdata_nxt = grant_we ? 32'h0 : mem_rdata;
            d_ack_nxt   = 1'b1;
          end else begin
            if_rdata_nxt = mem_rdata;
            if_ack_nxt   = 1'b1;
          end
        end
      end
      RESP: begin
        // No grant here, so a req still high during its ack is not re-issued.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A fetch that is not asking cannot be starved.
    if (!if_req)
      starve_cnt_nxt = 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_d    <= 1'b0;
      grant_we   <= 1'b0;
      wait_cnt   <= 4'd0;
      starve_cnt <= 4'd0;
      mem_ce     <= 1'b0;
      mem_we     <= 1'b0;
      mem_sel    <= 4'b0000;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= 32'h0;
      d_rdata    <= 32'h0;
    end else begin
      state      <= state_nxt;
      grant_d    <= grant_d_nxt;
      grant_we   <= grant_we_nxt;
      wait_cnt   <= wait_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
      mem_ce     <= mem_ce_nxt;
      mem_we     <= mem_we_nxt;
      mem_sel    <= mem_sel_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_ack     <= if_ack_nxt;
      d_ack      <= d_ack_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
    end
  end

  assign stallreq = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Directed self-checking bench for mem_bus_arbiter (MEM_LAT=2,
//             STARVE_MAX=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack;
  logic [3:0]  d_sel;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        stallreq;
  logic        mem_ce, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_sel    (d_sel),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .stallreq (stallreq),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_sel  (mem_sel),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_ce"},    {31'h0, mem_ce},   32'h0);
    check({tag, " mem_we"},    {31'h0, mem_we},   32'h0);
    check({tag, " mem_sel"},   {28'h0, mem_sel},  32'h0);
    check({tag, " mem_addr"},  mem_addr,          32'h0);
    check({tag, " mem_wdata"}, mem_wdata,         32'h0);
    check({tag, " if_ack"},    {31'h0, if_ack},   32'h0);
    check({tag, " d_ack"},     {31'h0, d_ack},    32'h0);
    check({tag, " if_rdata"},  if_rdata,          32'h0);
    check({tag, " d_rdata"},   d_rdata,           32'h0);
  endtask

  // Fetch from cycle T (called at a falling edge, with IDLE state).
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] rdata);
    if_req = 1'b1; if_addr = addr;
    #1 check({tag, " stall T"}, {31'h0, stallreq}, 32'h1);
    @(negedge clk);                                   // T+1 ACCESS
    check({tag, " ce T+1"},   {31'h0, mem_ce},  32'h1);
    check({tag, " sel T+1"},  {28'h0, mem_sel}, 32'hF);
    check({tag, " addr T+1"}, mem_addr,         addr);
    check({tag, " we T+1"},   {31'h0, mem_we},  32'h0);
    @(negedge clk);                                   // T+2 WAIT
    check({tag, " ce T+2"},   {31'h0, mem_ce},  32'h0);
    check({tag, " stall T+2"}, {31'h0, stallreq}, 32'h1);
    @(negedge clk);                                   // T+3 rdata valid
    mem_rdata = rdata;
    check({tag, " ack T+3"},  {31'h0, if_ack},  32'h0);
    @(negedge clk);                                   // T+4 RESP
    check({tag, " ack T+4"},   {31'h0, if_ack},   32'h1);
    check({tag, " rdata T+4"}, if_rdata,          rdata);
    check({tag, " d_ack T+4"}, {31'h0, d_ack},    32'h0);
    check({tag, " stall T+4"}, {31'h0, stallreq}, 32'h0);
    if_req = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check({tag, " ack T+5"},   {31'h0, if_ack},   32'h0);
  endtask

  task automatic do_data(input string tag, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata);
    d_req = 1'b1; d_we = we; d_sel = sel; d_addr = addr; d_wdata = wdata;
    @(negedge clk);                                   // T+1
    check({tag, " ce T+1"},    {31'h0, mem_ce},  32'h1);
    check({tag, " we T+1"},    {31'h0, mem_we},  {31'h0, we});
    check({tag, " sel T+1"},   {28'h0, mem_sel}, {28'h0, sel});
    check({tag, " addr T+1"},  mem_addr,         addr);
    check({tag, " wdata T+1"}, mem_wdata,        wdata);
    @(negedge clk);                                   // T+2
    @(negedge clk);                                   // T+3
    mem_rdata = rdata;
    check({tag, " ack T+3"},   {31'h0, d_ack},   32'h0);
    @(negedge clk);                                   // T+4
    check({tag, " ack T+4"},   {31'h0, d_ack},   32'h1);
    check({tag, " rdata T+4"}, d_rdata,          we ? 32'h0 : rdata);
    d_req = 1'b0; d_we = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check({tag, " ack T+5"},   {31'h0, d_ack},   32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int       acks;
    logic [5:0] seq;
    logic     both_seen;

    // ---------------- reset with random inputs ----------------
    rst = 1'b1;
    if_req = 1'($urandom); if_addr = $urandom; d_req = 1'($urandom); d_we = 1'($urandom);
    d_sel = 4'($urandom); d_addr = $urandom; d_wdata = $urandom; mem_rdata = $urandom;
    #22 check_all_zero("rst a");
    if_req = 1'b1; d_req = 1'b1; d_addr = $urandom; if_addr = $urandom; mem_rdata = $urandom;
    #20 check_all_zero("rst b");
    #8;                                               // t=50, falling edge
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_sel = 4'h0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle ce", {31'h0, mem_ce},   32'h0);
      check("idle stall", {31'h0, stallreq}, 32'h0);
    end

    // ---------------- single transactions ----------------
    do_fetch("fetch", 32'h0000_0010, 32'h3401_1100);
    do_data("dwrite", 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678);
    do_data("dread", 1'b0, 4'b1111, 32'h0000_0104, 32'h0, 32'hCAFE_F00D);

    // ---------------- collision ----------------
    if_req = 1'b1; if_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h0000_0080;   // T
    @(negedge clk);                                                    // T+1
    check("coll first addr", mem_addr, 32'h0000_0080);
    repeat (3) @(negedge clk);                                         // T+4
    check("coll d_ack T+4", {31'h0, d_ack},  32'h1);
    check("coll if_ack T+4", {31'h0, if_ack}, 32'h0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);                                         // T+6
    check("coll fetch ce T+6", {31'h0, mem_ce}, 32'h1);
    check("coll fetch addr T+6", mem_addr, 32'h0000_0040);
    repeat (2) @(negedge clk);                                         // T+8
    check("coll if_ack T+8", {31'h0, if_ack}, 32'h0);
    @(negedge clk);                                                    // T+9
    check("coll if_ack T+9", {31'h0, if_ack}, 32'h1);
    if_req = 1'b0;
    @(negedge clk);

    // ---------------- starvation guard ----------------
    if_req = 1'b1; if_addr = 32'h0000_0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    acks = 0; seq = 6'b0; both_seen = 1'b0;
    for (int c = 0; c < 80 && acks < 6; c++) begin
      @(negedge clk);
      if (if_ack && d_ack) both_seen = 1'b1;
      if (d_ack) begin
        seq[acks] = 1'b1; acks++;
      end else if (if_ack) begin
        seq[acks] = 1'b0; acks++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("starve ack count", acks, 32'd6);
    check("starve order d,d,d,d,f,d", {26'h0, seq}, 32'h2F);
    check("starve both acks", {31'h0, both_seen}, 32'h0);
    repeat (6) @(negedge clk);

    // ---------------- reset during WAIT ----------------
    if_req = 1'b1; if_addr = 32'h0000_0020;                            // T
    repeat (2) @(negedge clk);                                         // T+2 WAIT
    mem_rdata = 32'hBAD0_BAD0;
    rst = 1'b1;
    #1 check_all_zero("midrst");
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);                                                    // would-be ack
    check("midrst no ack", {31'h0, if_ack}, 32'h0);
    rst = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post rst no ack", {31'h0, if_ack}, 32'h0);
    end
    do_fetch("refetch", 32'h0000_0024, 32'h0042_0042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
